// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types, sizes and helpers for the shared-divider scheduler.
package div_sched_pkg;

  localparam int DIV_W     = 32;
  // The op record is sized for the widest supported tag and requester index.
  localparam int MAX_TAG_W = 16;
  localparam int MAX_ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [DIV_W-1:0]     dividend;
    logic [DIV_W-1:0]     divisor;
    logic [MAX_TAG_W-1:0] tag;
    logic [MAX_ID_W-1:0]  id;
  } div_op_t;

  // (base + off) mod n, assuming base < n and off <= n.
  function automatic int wrap_add(int base, int off, int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first active request at or after ptr.
module rr_arbiter
  import div_sched_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  // Walk the requesters starting at the pointer and grant the first one asking.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'(wrap_add(32'(ptr), i, NUM_REQ));
      if (!grant_any && req[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: shares one iterative divider between NUM_REQ requesters and
// returns results through a one-entry valid/ready response buffer.
// TAG_W must not exceed MAX_TAG_W and NUM_REQ must be in 2..8.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int TAG_W   = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     freeze_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_sign_i,
  input  logic [NUM_REQ*DIV_W-1:0] req_dividend_i,
  input  logic [NUM_REQ*DIV_W-1:0] req_divisor_i,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [TAG_W-1:0]         rsp_tag_o,
  output logic [DIV_W-1:0]         rsp_quotient_o,
  output logic [DIV_W-1:0]         rsp_remainder_o,
  output logic                     busy_o,
  output logic                     div_start_o,
  output logic                     div_stall_o,
  output logic                     div_sign_o,
  output logic [DIV_W-1:0]         div_dividend_o,
  output logic [DIV_W-1:0]         div_divisor_o,
  input  logic [DIV_W-1:0]         div_quotient_i,
  input  logic [DIV_W-1:0]         div_remainder_i,
  input  logic                     div_valid_i
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] next_ptr;
  div_op_t         op;
  div_op_t         next_op;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  logic accept;
  logic rsp_free;
  logic capture;
  logic unused_op_bits;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) arbiter (
    .req       (req_valid_i),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // A request is taken only from IDLE, and never while flushing, freezing or in reset.
  assign accept   = reset_i && (state == IDLE) && grant_any && !flush_i && !freeze_i;
  assign rsp_free = !rsp_valid_o || rsp_ready_i;
  // The divider result moves into the buffer only when the buffer has room this cycle.
  assign capture  = (state == RUN) && div_valid_i && rsp_free && !flush_i && !freeze_i;
  assign next_ptr = ID_W'(wrap_add(32'(grant_idx), 1, NUM_REQ));

  assign req_ready_o    = accept ? grant : '0;
  assign busy_o         = (state != IDLE);
  assign div_start_o    = reset_i && (state != IDLE) && !flush_i;
  // Stall the divider on freeze, or when its result is ready but cannot be stored.
  assign div_stall_o    = reset_i && !flush_i &&
                          (freeze_i || ((state == RUN) && div_valid_i && !rsp_free));
  assign div_sign_o     = op.sign;
  assign div_dividend_o = op.dividend;
  assign div_divisor_o  = op.divisor;

  // The upper tag/id bits are only there for wider configurations.
  assign unused_op_bits = ^{op.tag, op.id};

  // Mux the granted requester's operands into an op record.
  always_comb begin
    next_op    = '0;
    next_op.id = MAX_ID_W'(grant_idx);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        next_op.sign              = req_sign_i[k];
        next_op.dividend          = req_dividend_i[k*DIV_W +: DIV_W];
        next_op.divisor           = req_divisor_i[k*DIV_W +: DIV_W];
        next_op.tag[TAG_W-1:0]    = req_tag_i[k*TAG_W +: TAG_W];
      end
    end
  end

  // Scheduler FSM: latch a winner, spend one cycle loading the divider, then wait for it.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state  <= IDLE;
      rr_ptr <= '0;
      op     <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else if (!freeze_i) begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= ISSUE;
            op     <= next_op;
            rr_ptr <= next_ptr;
          end
        end
        ISSUE: state <= RUN;
        RUN: begin
          if (capture) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry response buffer; drains on handshake and refills in the same cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      rsp_valid_o     <= 1'b0;
      rsp_id_o        <= '0;
      rsp_tag_o       <= '0;
      rsp_quotient_o  <= '0;
      rsp_remainder_o <= '0;
    end else if (flush_i) begin
      rsp_valid_o     <= 1'b0;
      rsp_id_o        <= '0;
      rsp_tag_o       <= '0;
      rsp_quotient_o  <= '0;
      rsp_remainder_o <= '0;
    end else if (capture) begin
      rsp_valid_o     <= 1'b1;
      rsp_id_o        <= op.id[ID_W-1:0];
      rsp_tag_o       <= op.tag[TAG_W-1:0];
      rsp_quotient_o  <= div_quotient_i;
      rsp_remainder_o <= div_remainder_i;
    end else if (rsp_valid_o && rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_scheduler.sv
// tb_div_scheduler: randomized scoreboard bench for div_scheduler with a
// behavioural divider attached to the divider port.
module tb_div_scheduler;

  localparam int NREQ = 2;
  localparam int TW   = 4;

  typedef struct packed {
    logic [0:0]  id;
    logic [3:0]  tag;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              flush_i;
  logic              freeze_i;
  logic [NREQ-1:0]   req_valid_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   req_sign_i;
  logic [NREQ*32-1:0] req_dividend_i;
  logic [NREQ*32-1:0] req_divisor_i;
  logic [NREQ*TW-1:0] req_tag_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [0:0]        rsp_id_o;
  logic [TW-1:0]     rsp_tag_o;
  logic [31:0]       rsp_quotient_o;
  logic [31:0]       rsp_remainder_o;
  logic              busy_o;
  logic              div_start_o;
  logic              div_stall_o;
  logic              div_sign_o;
  logic [31:0]       div_dividend_o;
  logic [31:0]       div_divisor_o;
  logic [31:0]       div_quotient_i;
  logic [31:0]       div_remainder_i;
  logic              div_valid_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t sb[$];
  int   tb_ptr;
  logic hold_pending;
  exp_t hold_data;

  div_scheduler #(.NUM_REQ(NREQ), .TAG_W(TW)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .flush_i         (flush_i),
    .freeze_i        (freeze_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_sign_i      (req_sign_i),
    .req_dividend_i  (req_dividend_i),
    .req_divisor_i   (req_divisor_i),
    .req_tag_i       (req_tag_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_id_o        (rsp_id_o),
    .rsp_tag_o       (rsp_tag_o),
    .rsp_quotient_o  (rsp_quotient_o),
    .rsp_remainder_o (rsp_remainder_o),
    .busy_o          (busy_o),
    .div_start_o     (div_start_o),
    .div_stall_o     (div_stall_o),
    .div_sign_o      (div_sign_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i),
    .div_valid_i     (div_valid_i)
  );

  initial forever #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  // Reference division including the divider's x/0 and overflow conventions.
  function automatic logic [63:0] ref_div(logic s, logic [31:0] a, logic [31:0] d);
    int sa;
    int sd;
    if (d == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      if (a == 32'h8000_0000 && d == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      sa = $signed(a);
      sd = $signed(d);
      return {32'(sa / sd), 32'(sa % sd)};
    end
    return {a / d, a % d};
  endfunction

  // Divider iteration count: bit length of |dividend|, at least 3.
  function automatic int iter_count(logic s, logic [31:0] a);
    logic [31:0] m;
    int n;
    m = (s && a[31]) ? -a : a;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return (n < 3) ? 3 : n;
  endfunction

  function automatic int rr_pick(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural iterative divider: loads on the first start cycle, counts b cycles.
  logic dv_loaded;
  int   dv_cnt;
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dv_loaded       <= 1'b0;
      dv_cnt          <= 0;
      div_valid_i     <= 1'b0;
      div_quotient_i  <= 32'h0;
      div_remainder_i <= 32'h0;
    end else if (!div_start_o) begin
      dv_loaded   <= 1'b0;
      div_valid_i <= 1'b0;
    end else if (!div_stall_o) begin
      if (!dv_loaded) begin
        dv_loaded   <= 1'b1;
        dv_cnt      <= iter_count(div_sign_o, div_dividend_o);
        {div_quotient_i, div_remainder_i} <= ref_div(div_sign_o, div_dividend_o, div_divisor_o);
        div_valid_i <= 1'b0;
      end else if (dv_cnt > 1) begin
        dv_cnt <= dv_cnt - 1;
      end else if (dv_cnt == 1) begin
        dv_cnt      <= 0;
        div_valid_i <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string nm, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: predicts grants, fills the scoreboard, and checks every delivered response.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      tb_ptr       = 0;
      hold_pending = 1'b0;
      sb.delete();
    end else begin
      if (hold_pending)
        checkOutput("rsp_hold", 128'({rsp_valid_o, rsp_id_o, rsp_tag_o, rsp_quotient_o, rsp_remainder_o}),
                    128'({1'b1, hold_data}));
      if (flush_i || freeze_i) begin
        checkOutput("ready_gated", 128'(req_ready_o), 128'(0));
      end else if (req_ready_o != '0) begin
        int   pick;
        exp_t e;
        pick = rr_pick(req_valid_i, tb_ptr);
        if (pick < 0) begin
          checkOutput("grant_unrequested", 128'(req_ready_o), 128'(0));
        end else begin
          checkOutput("grant", 128'(req_ready_o), 128'(1) << pick);
          e.id  = 1'(pick);
          e.tag = req_tag_i[pick*TW +: TW];
          {e.q, e.r} = ref_div(req_sign_i[pick], req_dividend_i[pick*32 +: 32], req_divisor_i[pick*32 +: 32]);
          sb.push_back(e);
          tb_ptr = (pick + 1) % NREQ;
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          checkOutput("rsp_unexpected", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("rsp_data", 128'({rsp_id_o, rsp_tag_o, rsp_quotient_o, rsp_remainder_o}), 128'(e));
        end
      end
      hold_pending = rsp_valid_o && !rsp_ready_i && !flush_i;
      hold_data    = {rsp_id_o, rsp_tag_o, rsp_quotient_o, rsp_remainder_o};
      if (flush_i) sb.delete();
    end
  end

  // Present one request on requester k and hold it until it is accepted.
  task automatic applyStimulus(input int k, input logic s, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] tg, output int acc);
    acc = -1;
    @(posedge clk_i); #1;
    req_sign_i[k]              = s;
    req_dividend_i[k*32 +: 32] = a;
    req_divisor_i[k*32 +: 32]  = d;
    req_tag_i[k*TW +: TW]      = tg;
    req_valid_i[k]             = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (req_ready_o[k]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) checkOutput("accept_timeout", 128'(0), 128'(1));
    @(posedge clk_i); #1;
    req_valid_i[k] = 1'b0;
  endtask

  task automatic rand_req(input int k);
    logic [31:0] a;
    logic [31:0] d;
    a = $urandom >> $urandom_range(0, 31);
    d = $urandom >> $urandom_range(0, 31);
    case ($urandom_range(0, 7))
      0: d = 32'h0;
      1: d = 32'hFFFF_FFFF;
      2: begin a = 32'h8000_0000; d = 32'hFFFF_FFFF; end
      default: ;
    endcase
    req_sign_i[k]              = 1'($urandom_range(0, 1));
    req_dividend_i[k*32 +: 32] = a;
    req_divisor_i[k*32 +: 32]  = d;
    req_tag_i[k*TW +: TW]      = 4'($urandom);
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) checkOutput("rsp_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      if (!busy_o && !rsp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("idle_timeout", 128'(0), 128'(1));
  endtask

  // Single op with a known answer and latency; rsp_ready_i is expected high.
  task automatic run_one(input int k, input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] tg, input logic [31:0] eq, input logic [31:0] er,
                         input int lat);
    int acc;
    int at;
    applyStimulus(k, s, a, d, tg, acc);
    wait_rsp(at);
    checkOutput("latency", 128'(at - acc), 128'(lat));
    checkOutput("quotient", 128'(rsp_quotient_o), 128'(eq));
    checkOutput("remainder", 128'(rsp_remainder_o), 128'(er));
    checkOutput("id_tag", 128'({rsp_id_o, rsp_tag_o}), 128'({1'(k), tg}));
  endtask

  initial begin
    int          acc;
    int          at;
    int          grants;
    logic [3:0]  order;
    logic [1:0]  acc_mask;
    logic        seen;
    logic        done;

    reset_i        = 1'b0;
    flush_i        = 1'b0;
    freeze_i       = 1'b0;
    req_valid_i    = 2'b11;
    req_sign_i     = '0;
    req_dividend_i = {32'd40, 32'd30};
    req_divisor_i  = {32'd3, 32'd2};
    req_tag_i      = '0;
    rsp_ready_i    = 1'b1;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_ready", 128'(req_ready_o), 128'(0));
    checkOutput("reset_rsp_valid", 128'(rsp_valid_o), 128'(0));
    checkOutput("reset_busy", 128'(busy_o), 128'(0));
    checkOutput("reset_div_ctl", 128'({div_start_o, div_stall_o, div_sign_o}), 128'(0));
    checkOutput("reset_div_ops", 128'({div_dividend_o, div_divisor_o}), 128'(0));
    checkOutput("reset_rsp_data", 128'({rsp_id_o, rsp_tag_o, rsp_quotient_o, rsp_remainder_o}), 128'(0));
    @(posedge clk_i); #1;
    req_valid_i = '0;
    reset_i     = 1'b1;

    $display("[TB] directed operations");
    run_one(0, 1'b0, 32'd100, 32'd7, 4'h5, 32'd14, 32'd2, 10);
    run_one(1, 1'b1, 32'hFFFF_FFF9, 32'd2, 4'hA, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 6);
    run_one(0, 1'b0, 32'd5, 32'd0, 4'h3, 32'hFFFF_FFFF, 32'd5, 6);
    run_one(1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 4'hC, 32'h8000_0000, 32'h0, 35);

    $display("[TB] round robin");
    wait_idle();
    @(posedge clk_i); #1;
    rand_req(0);
    rand_req(1);
    req_valid_i = 2'b11;
    grants = 0;
    order  = '0;
    for (int n = 0; n < 400 && grants < 4; n++) begin
      @(negedge clk_i);
      acc_mask = req_ready_o;
      if (req_ready_o != '0) begin
        order[grants] = req_ready_o[1];
        grants++;
      end
      @(posedge clk_i); #1;
      for (int k = 0; k < NREQ; k++) if (acc_mask[k]) rand_req(k);
    end
    req_valid_i = '0;
    checkOutput("rr_count", 128'(grants), 128'(4));
    checkOutput("rr_order", 128'(order), 128'(4'b1010));
    wait_idle();

    $display("[TB] backpressure");
    rsp_ready_i = 1'b0;
    applyStimulus(0, 1'b0, 32'd20, 32'd3, 4'h1, acc);
    wait_rsp(at);
    applyStimulus(1, 1'b0, 32'd50, 32'd7, 4'h2, acc);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk_i);
      if (div_stall_o) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_stall", 128'(seen), 128'(1));
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("bp_stall_hold", 128'({div_stall_o, div_start_o, div_dividend_o}), 128'({2'b11, 32'd50}));
      checkOutput("bp_rsp_a", 128'({rsp_valid_o, rsp_id_o, rsp_quotient_o}), 128'({1'b1, 1'b0, 32'd6}));
    end
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_deliver_a", 128'({rsp_valid_o, rsp_id_o, div_stall_o}), 128'({1'b1, 1'b0, 1'b0}));
    @(negedge clk_i);
    checkOutput("bp_deliver_b", 128'({rsp_valid_o, rsp_id_o, rsp_quotient_o, rsp_remainder_o}),
                128'({1'b1, 1'b1, 32'd7, 32'd1}));
    wait_idle();

    $display("[TB] flush");
    applyStimulus(0, 1'b0, 32'hF000_0000, 32'd3, 4'h9, acc);
    repeat (4) @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    req_valid_i[1] = 1'b1;
    @(negedge clk_i);
    checkOutput("flush_outputs", 128'({req_ready_o, div_start_o, div_stall_o}), 128'(0));
    @(posedge clk_i); #1;
    flush_i        = 1'b0;
    req_valid_i[1] = 1'b0;
    @(negedge clk_i);
    checkOutput("flush_idle", 128'({busy_o, rsp_valid_o}), 128'(0));
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1'b1;
    end
    checkOutput("flush_no_rsp", 128'(seen), 128'(0));
    run_one(0, 1'b0, 32'd9, 32'd4, 4'h6, 32'd2, 32'd1, 7);

    $display("[TB] freeze");
    applyStimulus(1, 1'b0, 32'd1000, 32'd7, 4'hE, acc);
    repeat (3) @(posedge clk_i);
    #1;
    freeze_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("freeze_stall", 128'({div_stall_o, busy_o}), 128'(2'b11));
      @(posedge clk_i); #1;
    end
    freeze_i = 1'b0;
    wait_rsp(at);
    checkOutput("freeze_latency", 128'(at - acc), 128'(18));
    checkOutput("freeze_result", 128'({rsp_quotient_o, rsp_remainder_o}), 128'({32'd142, 32'd6}));
    wait_idle();

    $display("[TB] random traffic");
    acc_mask = '0;
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk_i); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc_mask[k]) req_valid_i[k] = 1'b0;
        if (!req_valid_i[k] && $urandom_range(0, 9) < 4) begin
          rand_req(k);
          req_valid_i[k] = 1'b1;
        end
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      freeze_i    = ($urandom_range(0, 19) == 0);
      @(negedge clk_i);
      acc_mask = req_ready_o & req_valid_i;
    end
    done = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk_i); #1;
      req_valid_i = req_valid_i & ~acc_mask;
      rsp_ready_i = 1'b1;
      freeze_i    = 1'b0;
      @(negedge clk_i);
      acc_mask = req_ready_o & req_valid_i;
      if (req_valid_i == '0 && !busy_o && !rsp_valid_o) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput("drain_done", 128'(done), 128'(1));
    checkOutput("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
